// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: opcode values,
// ALU control codes, FSM state encoding and decoded instruction classes.
package ctrl_pkg;

  localparam logic [3:0] OPC_LOAD  = 4'b0000;
  localparam logic [3:0] OPC_STORE = 4'b0001;
  localparam logic [3:0] OPC_MUL   = 4'b0010;
  localparam logic [3:0] OPC_ADD   = 4'b0100;
  localparam logic [3:0] OPC_ACT   = 4'b0110;
  localparam logic [3:0] OPC_HALT  = 4'b1111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_MUL  = 3'b010;
  localparam logic [2:0] ALU_ACT  = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_MEM     = 2'd1,
    CLS_HALT    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

endpackage

// File: rtl/control_seq_if.sv
// Bus between the control sequencer and its environment: instruction fetch,
// data-memory handshake, datapath controls and status.
interface control_seq_if #(
  parameter int INSTR_W = 8,
  parameter int OP_W    = 4,
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16
);
  localparam int OPND_W = INSTR_W - OP_W;

  logic               start;
  logic               imem_req;
  logic [PC_W-1:0]    pc;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [OP_W-1:0]    opcode;
  logic [OPND_W-1:0]  operand;
  logic [2:0]         alu_ctrl;
  logic               reg_we;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ready;
  logic               busy;
  logic               halted;
  logic               illegal_op;
  logic [CNT_W-1:0]   retired;

  modport master (
    input  start, instr_valid, instr, mem_ready,
    output imem_req, pc, opcode, operand, alu_ctrl, reg_we,
           mem_req, mem_we, busy, halted, illegal_op, retired
  );

  modport slave (
    output start, instr_valid, instr, mem_ready,
    input  imem_req, pc, opcode, operand, alu_ctrl, reg_we,
           mem_req, mem_we, busy, halted, illegal_op, retired
  );

endinterface

// File: rtl/ctrl_op_decode.sv
// Combinational opcode classifier shared by the DECODE transition and the
// datapath strobe logic.
module ctrl_op_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0] opcode,
  output op_class_t       op_class,
  output logic [2:0]      alu_ctrl,
  output logic            is_store
);

  logic upper_zero_s;

  // Any set bit above the 4-bit opcode space makes the instruction illegal.
  assign upper_zero_s = ((opcode >> 3'd4) == {OP_W{1'b0}});

  // Classify the opcode and select the ALU operation.
  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_ctrl = ALU_PASS;
    is_store = 1'b0;
    if (upper_zero_s) begin
      case (opcode[3:0])
        OPC_LOAD:  op_class = CLS_MEM;
        OPC_STORE: begin
          op_class = CLS_MEM;
          is_store = 1'b1;
        end
        OPC_MUL: begin
          op_class = CLS_ALU;
          alu_ctrl = ALU_MUL;
        end
        OPC_ADD: begin
          op_class = CLS_ALU;
          alu_ctrl = ALU_ADD;
        end
        OPC_ACT: begin
          op_class = CLS_ALU;
          alu_ctrl = ALU_ACT;
        end
        OPC_HALT:  op_class = CLS_HALT;
        default:   op_class = CLS_ILLEGAL;
      endcase
    end else begin
      op_class = CLS_ILLEGAL;
    end
  end

endmodule

// File: rtl/control_seq.sv
// Multi-cycle sequencing control unit: owns pc and ir, steps each instruction
// through FETCH/DECODE/EXEC or MEM with valid/ready handshakes.
module control_seq
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int OP_W    = 4,
  parameter int PC_W    = 8,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst_n,
  control_seq_if.master bus
);

  localparam int OPND_W = INSTR_W - OP_W;
  localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_next_s;
  logic [PC_W-1:0]    pc_r;
  logic [INSTR_W-1:0] ir_r;
  logic [CNT_W-1:0]   retired_r;
  logic               busy_r;
  logic               halted_r;

  op_class_t  dec_class_s;
  logic [2:0] dec_alu_s;
  logic       dec_store_s;

  logic       imem_req_s;
  logic [2:0] alu_ctrl_s;
  logic       reg_we_s;
  logic       mem_req_s;
  logic       mem_we_s;
  logic       illegal_op_s;
  logic       ir_load_s;
  logic       pc_inc_s;
  logic       run_clear_s;
  logic       ret_inc_s;

  ctrl_op_decode #(.OP_W(OP_W)) u_op_decode (
    .opcode   (ir_r[INSTR_W-1 -: OP_W]),
    .op_class (dec_class_s),
    .alu_ctrl (dec_alu_s),
    .is_store (dec_store_s)
  );

  // Next-state and strobe generation; strobes depend only on state and ir,
  // plus mem_ready for the LOAD write-back in MEM.
  always_comb begin
    state_next_s = state_r;
    imem_req_s   = 1'b0;
    alu_ctrl_s   = ALU_PASS;
    reg_we_s     = 1'b0;
    mem_req_s    = 1'b0;
    mem_we_s     = 1'b0;
    illegal_op_s = 1'b0;
    ir_load_s    = 1'b0;
    pc_inc_s     = 1'b0;
    run_clear_s  = 1'b0;
    ret_inc_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          run_clear_s  = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (bus.instr_valid) begin
          ir_load_s    = 1'b1;
          pc_inc_s     = 1'b1;
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (dec_class_s)
          CLS_ALU:  state_next_s = ST_EXEC;
          CLS_MEM:  state_next_s = ST_MEM;
          CLS_HALT: begin
            ret_inc_s    = 1'b1;
            state_next_s = ST_HALT;
          end
          CLS_ILLEGAL: begin
            illegal_op_s = 1'b1;
            state_next_s = ST_FETCH;
          end
          default: state_next_s = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        alu_ctrl_s   = dec_alu_s;
        reg_we_s     = 1'b1;
        ret_inc_s    = 1'b1;
        state_next_s = ST_FETCH;
      end
      ST_MEM: begin
        mem_req_s = 1'b1;
        mem_we_s  = dec_store_s;
        if (bus.mem_ready) begin
          reg_we_s     = ~dec_store_s;
          ret_inc_s    = 1'b1;
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_MEM;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, pc, ir, retired counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pc_r      <= {PC_W{1'b0}};
      ir_r      <= {INSTR_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      busy_r   <= (state_next_s != ST_IDLE) && (state_next_s != ST_HALT);
      halted_r <= (state_next_s == ST_HALT);
      if (ir_load_s) begin
        ir_r <= bus.instr;
      end
      if (run_clear_s) begin
        pc_r <= {PC_W{1'b0}};
      end else if (pc_inc_s) begin
        pc_r <= pc_r + PC_ONE;
      end
      // The counter saturates so a long run never reports a small count.
      if (run_clear_s) begin
        retired_r <= {CNT_W{1'b0}};
      end else if (ret_inc_s && (retired_r != CNT_MAX)) begin
        retired_r <= retired_r + CNT_ONE;
      end
    end
  end

  assign bus.imem_req   = imem_req_s;
  assign bus.pc         = pc_r;
  assign bus.opcode     = ir_r[INSTR_W-1 -: OP_W];
  assign bus.operand    = ir_r[OPND_W-1:0];
  assign bus.alu_ctrl   = alu_ctrl_s;
  assign bus.reg_we     = reg_we_s;
  assign bus.mem_req    = mem_req_s;
  assign bus.mem_we     = mem_we_s;
  assign bus.busy       = busy_r;
  assign bus.halted     = halted_r;
  assign bus.illegal_op = illegal_op_s;
  assign bus.retired    = retired_r;

endmodule
